// File: rtl/uart_tx_arbiter_pkg.sv
// Shared state encoding and constants for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RELEASE   = 2'd3
  } arb_state_e;

  localparam int UART_BYTE_W       = 8;
  localparam int DEFAULT_MAX_BURST = 16;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/serializer bundle; master is the arbiter side, slave the surrounding logic.
interface uart_tx_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ*UART_BYTE_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_last;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           grant_valid;
  logic [ID_W-1:0]                grant_id;
  logic [UART_BYTE_W-1:0]         tx_data;
  logic                           tx_start;
  logic                           tx_busy;
  logic                           tx_done;

  modport master (
    input  req, req_data, req_last, tx_busy, tx_done,
    output req_ready, grant_valid, grant_id, tx_data, tx_start
  );

  modport slave (
    output req, req_data, req_last, tx_busy, tx_done,
    input  req_ready, grant_valid, grant_id, tx_data, tx_start
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Rotating priority encoder: first set request after rr_ptr, wrapping modulo NUM_REQ.
module rr_picker #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               found,
  output logic [ID_W-1:0]    idx
);

  logic [ID_W-1:0] cand_s;

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
    return ID_W'((int'(base) + off) % NUM_REQ);
  endfunction

  // Scan farthest-first so the candidate nearest after rr_ptr is written last and wins.
  always_comb begin
    found  = 1'b0;
    idx    = {ID_W{1'b0}};
    cand_s = {ID_W{1'b0}};
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand_s = wrap_add(rr_ptr, i);
      found  = found | req[cand_s];
      idx    = req[cand_s] ? cand_s : idx;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART serializer among NUM_REQ requesters.
// Define UART_ARB_PRIO0_EN to give requester 0 fixed priority at each arbitration point.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int MAX_BURST = DEFAULT_MAX_BURST,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input logic               clk,
  input logic               rst,
  uart_tx_arbiter_if.master bus
);

  arb_state_e             state_r, state_s;
  logic [ID_W-1:0]        grant_id_r, rr_ptr_r;
  logic                   grant_valid_r, last_r, prio_hold_r;
  logic [7:0]             burst_cnt_r;
  logic                   tx_start_r;
  logic [UART_BYTE_W-1:0] tx_data_r;
  logic [NUM_REQ-1:0]     req_ready_r;

  logic                   pick_found_s, sel_found_s, prio0_s;
  logic [ID_W-1:0]        pick_idx_s, sel_idx_s;
  logic                   grant_s, issue_s, burst_full_s;
  logic [UART_BYTE_W-1:0] own_data_s;
  logic [NUM_REQ-1:0]     owner_onehot_s;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req    (bus.req),
    .rr_ptr (rr_ptr_r),
    .found  (pick_found_s),
    .idx    (pick_idx_s)
  );

`ifdef UART_ARB_PRIO0_EN
  assign prio0_s     = bus.req[0];
  assign sel_found_s = bus.req[0] | pick_found_s;
  assign sel_idx_s   = bus.req[0] ? {ID_W{1'b0}} : pick_idx_s;
`else
  assign prio0_s     = 1'b0;
  assign sel_found_s = pick_found_s;
  assign sel_idx_s   = pick_idx_s;
`endif

  assign own_data_s     = bus.req_data[UART_BYTE_W*int'(grant_id_r) +: UART_BYTE_W];
  assign owner_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_r;
  assign burst_full_s   = (burst_cnt_r == 8'(MAX_BURST));

  // Next-state and per-cycle action decode.
  always_comb begin
    state_s = state_r;
    grant_s = 1'b0;
    issue_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (sel_found_s) begin
          grant_s = 1'b1;
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (bus.tx_busy) begin
          state_s = ISSUE;
        end else if (bus.req[grant_id_r]) begin
          issue_s = 1'b1;
          state_s = WAIT_DONE;
        end else begin
          state_s = RELEASE;
        end
      end
      WAIT_DONE: begin
        if (bus.tx_done) begin
          state_s = (last_r || burst_full_s) ? RELEASE : ISSUE;
        end else begin
          state_s = WAIT_DONE;
        end
      end
      RELEASE: state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, grant bookkeeping and registered serializer/requester strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      grant_id_r    <= {ID_W{1'b0}};
      grant_valid_r <= 1'b0;
      rr_ptr_r      <= ID_W'(NUM_REQ - 1);
      burst_cnt_r   <= 8'd0;
      last_r        <= 1'b0;
      prio_hold_r   <= 1'b0;
      tx_start_r    <= 1'b0;
      tx_data_r     <= {UART_BYTE_W{1'b0}};
      req_ready_r   <= {NUM_REQ{1'b0}};
    end else begin
      state_r     <= state_s;
      tx_start_r  <= issue_s;
      req_ready_r <= issue_s ? owner_onehot_s : {NUM_REQ{1'b0}};
      if (grant_s) begin
        grant_id_r    <= sel_idx_s;
        grant_valid_r <= 1'b1;
        burst_cnt_r   <= 8'd0;
        prio_hold_r   <= prio0_s;
      end
      if (issue_s) begin
        tx_data_r <= own_data_s;
        last_r    <= bus.req_last[grant_id_r];
        if (!burst_full_s) begin
          burst_cnt_r <= burst_cnt_r + 8'd1;
        end
      end
      if (state_s == RELEASE) begin
        grant_valid_r <= 1'b0;
      end
      // A priority grant of requester 0 leaves the round-robin position untouched.
      if ((state_r == RELEASE) && !prio_hold_r) begin
        rr_ptr_r <= grant_id_r;
      end
    end
  end

  assign bus.tx_start    = tx_start_r;
  assign bus.tx_data     = tx_data_r;
  assign bus.req_ready   = req_ready_r;
  assign bus.grant_valid = grant_valid_r;
  assign bus.grant_id    = grant_id_r;

endmodule
